// File: rtl/weight_loader.sv
`default_nettype none
// ============================================================================
//  Module      : weight_loader
//  Description : Turns a valid/ready word stream (header + weights) into
//                one-hot write strobes for a layer's per-neuron weight
//                memories. Malformed headers raise a sticky error and their
//                payload is drained without writing.
//  Revision    : 1.0 - initial release
// ============================================================================
module weight_loader #(
   parameter int numNeurons   = 32,
   parameter int numWeight    = 784,
   parameter int addressWidth = 10,
   parameter int dataWidth    = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [31:0]             in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [numNeurons-1:0]   wen,
   output logic [addressWidth-1:0] wadd,
   output logic [dataWidth-1:0]    win,
   output logic                    done,
   output logic                    err
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic [31:0]           NUM_NEURONS = 32'(numNeurons);
   localparam logic [31:0]           NUM_WEIGHT  = 32'(numWeight);
   localparam logic [numNeurons-1:0] WEN_ONE     = {{(numNeurons-1){1'b0}}, 1'b1};

   logic [1:0]              state_q, state_d;
   logic [15:0]             bc_q, bc_d;
   logic [15:0]             cnt_q, cnt_d;
   logic [7:0]              nidx_q, nidx_d;
   logic                    ready_q;
   logic [numNeurons-1:0]   wen_q, wen_d;
   logic [addressWidth-1:0] wadd_q, wadd_d;
   logic [dataWidth-1:0]    win_q, win_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;

   // Header fields and per-beat conditions
   logic [15:0] hdr_cnt;
   logic [7:0]  hdr_nidx;
   logic        beat;
   logic        nidx_ok;
   logic        cnt_ok;
   logic        cnt_zero;
   logic        last_beat;

   assign hdr_cnt   = in_data[15:0];
   assign hdr_nidx  = in_data[23:16];
   assign beat      = in_valid && ready_q;
   assign nidx_ok   = {24'd0, hdr_nidx} < NUM_NEURONS;
   assign cnt_ok    = {16'd0, hdr_cnt} <= NUM_WEIGHT;
   assign cnt_zero  = (hdr_cnt == 16'd0);
   // bc counts accepted payload words; the final one arrives when bc == cnt-1
   assign last_beat = (bc_q == (cnt_q - 16'd1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; only accepted beats move the FSM
   always_comb begin
      state_d = state_q;
      if (beat) begin
         case (state_q)
            ST_IDLE: begin
               if (!cnt_zero) begin
                  if (nidx_ok && cnt_ok) state_d = ST_LOAD;
                  else                   state_d = ST_DRAIN;
               end
            end
            ST_LOAD:  if (last_beat) state_d = ST_IDLE;
            ST_DRAIN: if (last_beat) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Output/datapath next values; address and data hold when no write
   always_comb begin
      bc_d   = bc_q;
      cnt_d  = cnt_q;
      nidx_d = nidx_q;
      wen_d  = '0;
      wadd_d = wadd_q;
      win_d  = win_q;
      done_d = 1'b0;
      err_d  = err_q;
      if (beat) begin
         case (state_q)
            ST_IDLE: begin
               if (nidx_ok && cnt_ok) begin
                  err_d = 1'b0;
                  if (cnt_zero) begin
                     done_d = 1'b1;
                  end else begin
                     nidx_d = hdr_nidx;
                     cnt_d  = hdr_cnt;
                     bc_d   = 16'd0;
                  end
               end else begin
                  err_d = 1'b1;
                  if (!cnt_zero) begin
                     cnt_d = hdr_cnt;
                     bc_d  = 16'd0;
                  end
               end
            end
            ST_LOAD: begin
               wen_d  = WEN_ONE << nidx_q;
               wadd_d = bc_q[addressWidth-1:0];
               win_d  = in_data[dataWidth-1:0];
               bc_d   = bc_q + 16'd1;
               done_d = last_beat;
            end
            ST_DRAIN: begin
               bc_d = bc_q + 16'd1;
            end
            default: ;
         endcase
      end
   end

   // Registered outputs and datapath; reset clears strobes immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bc_q    <= 16'd0;
         cnt_q   <= 16'd0;
         nidx_q  <= 8'd0;
         ready_q <= 1'b0;
         wen_q   <= '0;
         wadd_q  <= '0;
         win_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         bc_q    <= bc_d;
         cnt_q   <= cnt_d;
         nidx_q  <= nidx_d;
         ready_q <= 1'b1;
         wen_q   <= wen_d;
         wadd_q  <= wadd_d;
         win_q   <= win_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign in_ready = ready_q;
   assign wen      = wen_q;
   assign wadd     = wadd_q;
   assign win      = win_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_weight_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_weight_loader
//  Description : Self-checking bench for weight_loader. Expected writes are
//                queued as stimulus is driven and matched against the write
//                port by a monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_loader;

   localparam int NN = 32;
   localparam int NW = 784;
   localparam int AW = 10;
   localparam int DW = 16;

   logic          clk;
   logic          rst_n;
   logic [31:0]   in_data;
   logic          in_valid;
   logic          in_ready;
   logic [NN-1:0] wen;
   logic [AW-1:0] wadd;
   logic [DW-1:0] win;
   logic          done;
   logic          err;

   weight_loader #(
      .numNeurons  (NN),
      .numWeight   (NW),
      .addressWidth(AW),
      .dataWidth   (DW)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_data (in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .wen     (wen),
      .wadd    (wadd),
      .win     (win),
      .done    (done),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [NN-1:0] wen;
      logic [AW-1:0] wadd;
      logic [DW-1:0] win;
      logic          done;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   done_cnt = 0;

   // Monitor: every write or done pulse must match the head of the queue
   always @(negedge clk) begin
      if (rst_n && (wen != '0 || done)) begin
         n_checks++;
         if (done) done_cnt++;
         if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_output: wen=%h wadd=%0d win=%h done=%b, required no output",
                     wen, wadd, win, done);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (wen !== e.wen || done !== e.done ||
                (e.wen != '0 && (wadd !== e.wadd || win !== e.win))) begin
               n_errors++;
               $display("FAIL write_port: wen=%h wadd=%0d win=%h done=%b, required wen=%h wadd=%0d win=%h done=%b",
                        wen, wadd, win, done, e.wen, e.wadd, e.win, e.done);
            end
         end
      end
   end

   function automatic logic [31:0] hdr(input int nidx, input int cnt);
      logic [31:0] h;
      h = {8'hA5, nidx[7:0], cnt[15:0]};
      return h;
   endfunction

   task automatic push(input int n, input int a, input int d, input logic dn);
      exp_t e;
      e.wen  = (n < 0) ? '0 : ({{(NN-1){1'b0}}, 1'b1} << n);
      e.wadd = a[AW-1:0];
      e.win  = d[DW-1:0];
      e.done = dn;
      sb.push_back(e);
   endtask

   task automatic beat(input logic [31:0] w);
      in_valid = 1'b1;
      in_data  = w;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 32'h0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_drained(input string name);
      idle(2);
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL %s_pending: %0d writes outstanding, required 0", name, sb.size());
      end
      sb.delete();
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 32'h0;
      idle(3);
      n_checks++;
      if ({in_ready, wen, wadd, win, done, err} !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs: ready=%b wen=%h wadd=%0d win=%h done=%b err=%b, required all 0",
                  in_ready, wen, wadd, win, done, err);
      end
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL ready_before_edge: %b, required 0", in_ready);
      end
      idle(1);
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL ready_after_edge: %b, required 1", in_ready);
      end
   endtask

   task automatic test_good_load();
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < 4; i++) push(3, i, 16'h11 * (i + 1), i == 3);
      beat(hdr(3, 4));
      for (int i = 0; i < 4; i++) beat(32'hDEAD0000 | (32'h11 * (i + 1)));
      n_checks++;
      if (err !== 1'b0) begin
         n_errors++;
         $display("FAIL good_err: %b, required 0", err);
      end
      check_drained("good");
      n_checks++;
      if (done_cnt - d0 != 1) begin
         n_errors++;
         $display("FAIL good_done_count: %0d, required 1", done_cnt - d0);
      end
   endtask

   task automatic test_gapped();
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < 4; i++) push(3, i, 16'h11 * (i + 1), i == 3);
      beat(hdr(3, 4));
      beat(32'h11);
      beat(32'h22);
      idle(1);
      n_checks++;
      if (wen !== '0) begin
         n_errors++;
         $display("FAIL gap_wen: %h, required 0", wen);
      end
      idle(1);
      beat(32'h33);
      beat(32'h44);
      check_drained("gapped");
      n_checks++;
      if (done_cnt - d0 != 1) begin
         n_errors++;
         $display("FAIL gapped_done_count: %0d, required 1", done_cnt - d0);
      end
   endtask

   task automatic test_bad_neuron();
      int d0;
      d0 = done_cnt;
      beat(hdr(200, 0));
      n_checks++;
      if (err !== 1'b1) begin
         n_errors++;
         $display("FAIL bad_zero_err: %b, required 1", err);
      end
      beat(hdr(NN, 2));
      beat(hdr(0, 1));
      beat(hdr(0, 1));
      n_checks++;
      if (err !== 1'b1) begin
         n_errors++;
         $display("FAIL bad_drain_err: %b, required 1", err);
      end
      push(0, 0, 16'h55, 1'b1);
      beat(hdr(0, 1));
      n_checks++;
      if (err !== 1'b0) begin
         n_errors++;
         $display("FAIL bad_err_clear: %b, required 0", err);
      end
      beat(32'h55);
      check_drained("bad_neuron");
      n_checks++;
      if (done_cnt - d0 != 1) begin
         n_errors++;
         $display("FAIL bad_done_count: %0d, required 1", done_cnt - d0);
      end
   endtask

   task automatic test_oversize();
      int d0;
      d0 = done_cnt;
      beat(hdr(7, NW + 1));
      for (int i = 0; i < NW + 1; i++) beat($urandom);
      n_checks++;
      if (err !== 1'b1 || done_cnt != d0) begin
         n_errors++;
         $display("FAIL oversize_drain: err=%b done=%0d, required err=1 done=0", err, done_cnt - d0);
      end
      push(5, 0, 16'h66, 1'b1);
      beat(hdr(5, 1));
      beat(32'h66);
      check_drained("oversize");
   endtask

   task automatic test_back_to_back();
      int d0;
      d0 = done_cnt;
      push(-1, 0, 0, 1'b1);
      push(1, 0, 16'hA1, 1'b0);
      push(1, 1, 16'hA2, 1'b1);
      push(4, 0, 16'hB1, 1'b1);
      beat(hdr(2, 0));
      n_checks++;
      if (done !== 1'b1 || wen !== '0) begin
         n_errors++;
         $display("FAIL zero_cnt_done: done=%b wen=%h, required done=1 wen=0", done, wen);
      end
      beat(hdr(1, 2));
      beat(32'hA1);
      n_checks++;
      if (wen !== NN'(2)) begin
         n_errors++;
         $display("FAIL b2b_first_write: wen=%h, required %h", wen, NN'(2));
      end
      beat(32'hA2);
      beat(hdr(4, 1));
      beat(32'hB1);
      check_drained("back_to_back");
      n_checks++;
      if (done_cnt - d0 != 3) begin
         n_errors++;
         $display("FAIL b2b_done_count: %0d, required 3", done_cnt - d0);
      end
   endtask

   task automatic test_reset_mid_load();
      for (int i = 0; i < 3; i++) push(6, i, 16'h100 + i, 1'b0);
      beat(hdr(6, 8));
      for (int i = 0; i < 3; i++) beat(32'h100 + i);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({in_ready, wen, wadd, win, done, err} !== '0) begin
         n_errors++;
         $display("FAIL midload_reset_outputs: ready=%b wen=%h wadd=%0d win=%h done=%b err=%b, required all 0",
                  in_ready, wen, wadd, win, done, err);
      end
      check_drained("pre_reset");
      rst_n = 1'b1;
      idle(1);
      push(2, 0, 16'h77, 1'b1);
      beat(hdr(2, 1));
      beat(32'h77);
      check_drained("after_reset");
   endtask

   initial begin
      test_reset();
      test_good_load();
      test_gapped();
      test_bad_neuron();
      test_oversize();
      test_back_to_back();
      test_reset_mid_load();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
